// File: rtl/noc_packet_checker.sv
// Receive-side NoC endpoint: validates header/data/tail flit streams and
// reports per-packet status plus saturating good/bad packet counters.
module noc_packet_checker #(
  parameter int                ID_X_W       = 4,
  parameter int                ID_Y_W       = 4,
  parameter logic [ID_X_W-1:0] X_ID         = '0,
  parameter logic [ID_Y_W-1:0] Y_ID         = '0,
  parameter int                DATA_W       = 64,
  parameter logic [7:0]        HEAD_H       = 8'hF0,
  parameter logic [7:0]        HEAD_E       = 8'h0F,
  parameter logic [7:0]        TAIL_H       = 8'hE0,
  parameter logic [7:0]        TAIL_E       = 8'h0E,
  parameter logic [DATA_W-1:0] DATA_PATTERN = '1
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  input  logic              rx_stall,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [ID_X_W-1:0] pkt_src_x,
  output logic [ID_Y_W-1:0] pkt_src_y,
  output logic [7:0]        pkt_len,
  output logic [4:0]        pkt_err,
  output logic              err_stray,
  output logic [15:0]       rx_pkt_cnt,
  output logic [15:0]       err_cnt
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_TAIL, S_DROP} state_t;

  localparam int HM_LSB  = DATA_W - 8;
  localparam int SX_LSB  = HM_LSB - ID_X_W;
  localparam int SY_LSB  = SX_LSB - ID_Y_W;
  localparam int DX_LSB  = SY_LSB - ID_X_W;
  localparam int DY_LSB  = DX_LSB - ID_Y_W;
  localparam int LEN_LSB = DY_LSB - 8;
  localparam int EM_LSB  = LEN_LSB - 8;

  localparam logic [4:0] ERR_MARKER = 5'b00001;
  localparam logic [4:0] ERR_DEST   = 5'b00010;
  localparam logic [4:0] ERR_LEN    = 5'b00100;
  localparam logic [4:0] ERR_DATA   = 5'b01000;
  localparam logic [4:0] ERR_TAIL   = 5'b10000;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic [4:0]        err_q, err_d, close_err_d, hdr_err;
  logic [7:0]        cnt_q, cnt_d, len_q, len_d;
  logic [ID_X_W-1:0] src_x_q, src_x_d, dst_x_q, dst_x_d;
  logic [ID_Y_W-1:0] src_y_q, src_y_d, dst_y_q, dst_y_d;
  logic              close_d, stray_d, acc, tail_bad;

  logic              pkt_done_q, pkt_ok_q, err_stray_q;
  logic [ID_X_W-1:0] pkt_src_x_q;
  logic [ID_Y_W-1:0] pkt_src_y_q;
  logic [7:0]        pkt_len_q;
  logic [4:0]        pkt_err_q;
  logic [15:0]       rx_pkt_cnt_q, err_cnt_q;

  logic [7:0]        f_hm, f_em, f_len;
  logic [ID_X_W-1:0] f_sx, f_dx;
  logic [ID_Y_W-1:0] f_sy, f_dy;

  assign f_hm  = receive_flit[HM_LSB +: 8];
  assign f_sx  = receive_flit[SX_LSB +: ID_X_W];
  assign f_sy  = receive_flit[SY_LSB +: ID_Y_W];
  assign f_dx  = receive_flit[DX_LSB +: ID_X_W];
  assign f_dy  = receive_flit[DY_LSB +: ID_Y_W];
  assign f_len = receive_flit[LEN_LSB +: 8];
  assign f_em  = receive_flit[EM_LSB +: 8];
  assign acc   = receive_valid && receive_ready;

  // A flag-conflicted flit is still taken as a header, but marked bad.
  always_comb begin
    hdr_err    = '0;
    hdr_err[0] = (f_hm != HEAD_H) || (f_em != HEAD_E) || receive_is_tail;
    hdr_err[1] = (f_dx != X_ID) || (f_dy != Y_ID);
    tail_bad   = (f_hm != TAIL_H) || (f_em != TAIL_E) || (f_sx != src_x_q) ||
                 (f_sy != src_y_q) || (f_dx != dst_x_q) || (f_dy != dst_y_q) ||
                 (f_len != len_q);
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q      <= S_HDR;
      err_q        <= '0;
      pkt_done_q   <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_src_x_q  <= '0;
      pkt_src_y_q  <= '0;
      pkt_len_q    <= '0;
      pkt_err_q    <= '0;
      err_stray_q  <= 1'b0;
      rx_pkt_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      pkt_done_q  <= close_d;
      err_stray_q <= stray_d;
      if (close_d) begin
        pkt_ok_q    <= (close_err_d == '0);
        pkt_src_x_q <= src_x_q;
        pkt_src_y_q <= src_y_q;
        pkt_len_q   <= len_q;
        pkt_err_q   <= close_err_d;
        if (close_err_d == '0) rx_pkt_cnt_q <= sat_inc(rx_pkt_cnt_q);
        else                   err_cnt_q    <= sat_inc(err_cnt_q);
      end
    end
  end

  // Packet context is always reloaded by a header before it is consulted.
  always_ff @(posedge noc_clk) begin
    cnt_q   <= cnt_d;
    len_q   <= len_d;
    src_x_q <= src_x_d;
    src_y_q <= src_y_d;
    dst_x_q <= dst_x_d;
    dst_y_q <= dst_y_d;
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    close_d     = 1'b0;
    close_err_d = err_q;
    stray_d     = 1'b0;
    if (acc) begin
      if (receive_is_header) begin
        if (state_q != S_HDR) begin
          close_d     = 1'b1;
          close_err_d = err_q | ERR_LEN;
        end
        src_x_d = f_sx;
        src_y_d = f_sy;
        dst_x_d = f_dx;
        dst_y_d = f_dy;
        len_d   = f_len;
        cnt_d   = f_len;
        err_d   = hdr_err;
        state_d = (hdr_err != '0) ? S_DROP : S_DATA;
      end else begin
        case (state_q)
          S_HDR: stray_d = 1'b1;
          S_DATA: begin
            if (receive_is_tail) begin
              close_d     = 1'b1;
              close_err_d = err_q | ERR_LEN;
              state_d     = S_HDR;
            end else begin
              if (receive_flit != DATA_PATTERN) err_d = err_q | ERR_DATA;
              if (cnt_q == 8'd0) state_d = S_TAIL;
              else               cnt_d   = cnt_q - 8'd1;
            end
          end
          S_TAIL: begin
            if (receive_is_tail) begin
              close_d     = 1'b1;
              close_err_d = tail_bad ? (err_q | ERR_TAIL) : err_q;
              state_d     = S_HDR;
            end else begin
              err_d   = err_q | ERR_LEN;
              state_d = S_DROP;
            end
          end
          default: begin
            if (receive_is_tail) begin
              close_d = 1'b1;
              state_d = S_HDR;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    receive_ready = noc_rst_n && !rx_stall;
    pkt_done      = pkt_done_q;
    pkt_ok        = pkt_ok_q;
    pkt_src_x     = pkt_src_x_q;
    pkt_src_y     = pkt_src_y_q;
    pkt_len       = pkt_len_q;
    pkt_err       = pkt_err_q;
    err_stray     = err_stray_q;
    rx_pkt_cnt    = rx_pkt_cnt_q;
    err_cnt       = err_cnt_q;
  end

endmodule

// File: tb/tb_noc_packet_checker.sv
// Directed bench for noc_packet_checker at default parameters (node (0,0)).
module tb_noc_packet_checker;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [63:0] receive_flit = '0;
  logic        receive_is_header = 1'b0;
  logic        receive_is_tail = 1'b0;
  logic        rx_stall = 1'b0;
  logic        pkt_done, pkt_ok, err_stray;
  logic [3:0]  pkt_src_x, pkt_src_y;
  logic [7:0]  pkt_len;
  logic [4:0]  pkt_err;
  logic [15:0] rx_pkt_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  noc_packet_checker dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail), .rx_stall(rx_stall),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_src_x(pkt_src_x),
    .pkt_src_y(pkt_src_y), .pkt_len(pkt_len), .pkt_err(pkt_err),
    .err_stray(err_stray), .rx_pkt_cnt(rx_pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  function automatic logic [63:0] mk(input logic [7:0] hm, input logic [3:0] sx,
                                     input logic [3:0] sy, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [7:0] len,
                                     input logic [7:0] em);
    return {hm, sx, sy, dx, dy, len, em, 24'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one flit at the falling edge; return just after the accepting edge.
  task automatic send(input logic [63:0] f, input logic h, input logic t);
    @(negedge noc_clk);
    receive_valid = 1'b1; receive_flit = f;
    receive_is_header = h; receive_is_tail = t; rx_stall = 1'b0;
    @(posedge noc_clk); #1;
  endtask

  task automatic idle();
    @(negedge noc_clk);
    receive_valid = 1'b0; receive_is_header = 1'b0; receive_is_tail = 1'b0;
    @(posedge noc_clk); #1;
  endtask

  // One stalled cycle, then the same flit is accepted.
  task automatic send_stalled(input logic [63:0] f, input logic h, input logic t);
    @(negedge noc_clk);
    receive_valid = 1'b1; receive_flit = f;
    receive_is_header = h; receive_is_tail = t; rx_stall = 1'b1;
    #1 chk("stall_ready", receive_ready, 1'b0);
    @(posedge noc_clk); #1;
    chk("stall_no_done", pkt_done, 1'b0);
    send(f, h, t);
  endtask

  logic [63:0] DATA1, H12, T12, H12D33, H12L2, T12L2, H34, T34, T52;

  initial begin
    DATA1  = '1;
    H12    = mk(8'hF0, 4'd1, 4'd2, 4'd0, 4'd0, 8'd0, 8'h0F);
    T12    = mk(8'hE0, 4'd1, 4'd2, 4'd0, 4'd0, 8'd0, 8'h0E);
    H12D33 = mk(8'hF0, 4'd1, 4'd2, 4'd3, 4'd3, 8'd0, 8'h0F);
    H12L2  = mk(8'hF0, 4'd1, 4'd2, 4'd0, 4'd0, 8'd2, 8'h0F);
    T12L2  = mk(8'hE0, 4'd1, 4'd2, 4'd0, 4'd0, 8'd2, 8'h0E);
    H34    = mk(8'hF0, 4'd3, 4'd4, 4'd0, 4'd0, 8'd0, 8'h0F);
    T34    = mk(8'hE0, 4'd3, 4'd4, 4'd0, 4'd0, 8'd0, 8'h0E);
    T52    = mk(8'hE0, 4'd5, 4'd2, 4'd0, 4'd0, 8'd0, 8'h0E);

    #12;
    chk("rst_ready", receive_ready, 1'b0);
    chk("rst_done", pkt_done, 1'b0);
    chk("rst_rxcnt", rx_pkt_cnt, 16'd0);
    chk("rst_errcnt", err_cnt, 16'd0);
    chk("rst_err", pkt_err, 5'd0);
    @(negedge noc_clk); noc_rst_n = 1'b1;
    #1 chk("ready_after_rst", receive_ready, 1'b1);

    send(H12, 1, 0);
    send(DATA1, 0, 0);
    chk("good_no_early_done", pkt_done, 1'b0);
    send(T12, 0, 1);
    chk("good_done", pkt_done, 1'b1);
    chk("good_ok", pkt_ok, 1'b1);
    chk("good_src", {pkt_src_x, pkt_src_y}, 8'h12);
    chk("good_len", pkt_len, 8'd0);
    chk("good_err", pkt_err, 5'd0);
    chk("good_rxcnt", rx_pkt_cnt, 16'd1);
    idle();
    chk("done_pulse", pkt_done, 1'b0);
    chk("src_hold", {pkt_src_x, pkt_src_y}, 8'h12);

    send_stalled(H12, 1, 0);
    send_stalled(DATA1, 0, 0);
    send_stalled(T12, 0, 1);
    chk("stall_done", pkt_done, 1'b1);
    chk("stall_ok", pkt_ok, 1'b1);
    chk("stall_src", {pkt_src_x, pkt_src_y}, 8'h12);
    chk("stall_rxcnt", rx_pkt_cnt, 16'd2);

    send(H12D33, 1, 0);
    send(DATA1, 0, 0);
    send(T12, 0, 1);
    chk("dest_done", pkt_done, 1'b1);
    chk("dest_ok", pkt_ok, 1'b0);
    chk("dest_err", pkt_err, 5'b00010);
    chk("dest_errcnt", err_cnt, 16'd1);
    chk("dest_rxcnt", rx_pkt_cnt, 16'd2);

    send(H12L2, 1, 0);
    send(DATA1, 0, 0);
    send(DATA1, 0, 0);
    send(T12L2, 0, 1);
    chk("len_done", pkt_done, 1'b1);
    chk("len_err", pkt_err, 5'b00100);
    chk("len_pktlen", pkt_len, 8'd2);
    chk("len_errcnt", err_cnt, 16'd2);

    send(H12, 1, 0);
    send(64'h0, 0, 0);
    send(T12, 0, 1);
    chk("data_err", pkt_err, 5'b01000);
    chk("data_errcnt", err_cnt, 16'd3);
    idle();

    send(DATA1, 0, 0);
    chk("stray_pulse", err_stray, 1'b1);
    chk("stray_no_done", pkt_done, 1'b0);
    idle();
    chk("stray_clear", err_stray, 1'b0);
    chk("stray_rxcnt", rx_pkt_cnt, 16'd2);
    chk("stray_errcnt", err_cnt, 16'd3);

    send(H12, 1, 0);
    send(H34, 1, 0);
    chk("mid_hdr_done1", pkt_done, 1'b1);
    chk("mid_hdr_err1", pkt_err, 5'b00100);
    chk("mid_hdr_src1", {pkt_src_x, pkt_src_y}, 8'h12);
    chk("mid_hdr_errcnt", err_cnt, 16'd4);
    send(DATA1, 0, 0);
    chk("mid_hdr_gap", pkt_done, 1'b0);
    send(T34, 0, 1);
    chk("mid_hdr_done2", pkt_done, 1'b1);
    chk("mid_hdr_ok2", pkt_ok, 1'b1);
    chk("mid_hdr_src2", {pkt_src_x, pkt_src_y}, 8'h34);
    chk("mid_hdr_rxcnt", rx_pkt_cnt, 16'd3);

    send(H12, 1, 0);
    send(DATA1, 0, 0);
    send(T52, 0, 1);
    chk("tailid_err", pkt_err, 5'b10000);
    chk("tailid_errcnt", err_cnt, 16'd5);

    send(H12, 1, 1);
    send(DATA1, 0, 0);
    send(T12, 0, 1);
    chk("both_flags_err", pkt_err, 5'b00001);
    chk("both_flags_errcnt", err_cnt, 16'd6);

    send(H12, 1, 0);
    @(negedge noc_clk);
    receive_valid = 1'b0; receive_is_header = 1'b0; noc_rst_n = 1'b0;
    #1;
    chk("mrst_ready", receive_ready, 1'b0);
    chk("mrst_err", pkt_err, 5'd0);
    chk("mrst_src", {pkt_src_x, pkt_src_y}, 8'h00);
    chk("mrst_rxcnt", rx_pkt_cnt, 16'd0);
    chk("mrst_errcnt", err_cnt, 16'd0);
    @(negedge noc_clk); noc_rst_n = 1'b1;
    send(DATA1, 0, 0);
    chk("mrst_stray", err_stray, 1'b1);
    send(T12, 0, 1);
    chk("mrst_no_done", pkt_done, 1'b0);
    chk("mrst_errcnt2", err_cnt, 16'd0);

    // Every header after the first closes the previous packet as short.
    for (int i = 0; i < 65536; i++) send(H12, 1, 0);
    chk("sat_reach", err_cnt, 16'hFFFF);
    send(H12, 1, 0);
    chk("sat_done", pkt_done, 1'b1);
    chk("sat_hold", err_cnt, 16'hFFFF);
    send(DATA1, 0, 0);
    send(T12, 0, 1);
    chk("sat_rxcnt", rx_pkt_cnt, 16'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
